// File: rtl/ram_march_tester.sv
// March BIST initiator for a single-port synchronous RAM: write/verify a
// per-address pattern ascending, then its inverse descending, and log the first mismatch.
module ram_march_tester #(
  parameter int                ADDR_W  = 5,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(32'hA5A5_5A5A),
  parameter int                CNT_W   = ADDR_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [CNT_W-1:0]  err_count,
  output logic              mem_ena,
  output logic              mem_wena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, WR_P, RD_P_A, RD_P_C, WR_N, RD_N_A, RD_N_C, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t state;

  function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a);
    return PATTERN ^ DATA_W'(a);
  endfunction

  // mem_addr doubles as the march address counter; it is 0 outside the march.
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_dec;
  logic [DATA_W-1:0] exp_word;
  logic              mismatch;

  assign addr_inc = mem_addr + ADDR_W'(1);
  assign addr_dec = mem_addr - ADDR_W'(1);
  assign exp_word = (state == RD_N_C) ? ~word_at(mem_addr) : word_at(mem_addr);
  assign mismatch = ((state == RD_P_C) || (state == RD_N_C)) && (mem_rdata != exp_word);

  // NOTE: all state and outputs update with non-blocking assignments in one
  // clocked block, so every output is a register and no ordering races exist.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      err_count <= '0;
      mem_ena   <= 1'b0;
      mem_wena  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (mismatch) begin
        if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= mem_addr;
          fail_exp  <= exp_word;
          fail_got  <= mem_rdata;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= WR_P;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
            err_count <= '0;
            mem_ena   <= 1'b1;
            mem_wena  <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= word_at('0);
          end
        end

        WR_P: begin
          if (mem_addr == ADDR_MAX) begin
            state     <= RD_P_A;
            mem_wena  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else begin
            mem_addr  <= addr_inc;
            mem_wdata <= word_at(addr_inc);
          end
        end

        RD_P_A: state <= RD_P_C;

        // Compare happens at this state's closing edge; address is held so a
        // registered-read RAM has its data ready by now.
        RD_P_C: begin
          if (mem_addr == ADDR_MAX) begin
            state     <= WR_N;
            mem_wena  <= 1'b1;
            mem_addr  <= ADDR_MAX;
            mem_wdata <= ~word_at(ADDR_MAX);
          end else begin
            state    <= RD_P_A;
            mem_addr <= addr_inc;
          end
        end

        WR_N: begin
          if (mem_addr == '0) begin
            state     <= RD_N_A;
            mem_wena  <= 1'b0;
            mem_addr  <= ADDR_MAX;
            mem_wdata <= '0;
          end else begin
            mem_addr  <= addr_dec;
            mem_wdata <= ~word_at(addr_dec);
          end
        end

        RD_N_A: state <= RD_N_C;

        RD_N_C: begin
          if (mem_addr == '0) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            mem_ena  <= 1'b0;
            mem_addr <= '0;
          end else begin
            state    <= RD_N_A;
            mem_addr <= addr_dec;
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          mem_ena  <= 1'b0;
          mem_wena <= 1'b0;
          mem_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_march_tester.sv
// Scoreboarded bench for ram_march_tester: a faulty RAM model, an abstract
// march reference, and a negedge monitor that checks writes and final results.
module tb_ram_march_tester;

  localparam int          ADDR_W  = 5;
  localparam int          DATA_W  = 32;
  localparam int          CNT_W   = ADDR_W + 2;
  localparam int          N       = 1 << ADDR_W;
  localparam logic [31:0] PATTERN = 32'hA5A5_5A5A;

  typedef enum int {F_NONE, F_STUCK0, F_STUCK1, F_ALIAS, F_FLIP} fault_t;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        fail;
    logic [4:0]  addr;
    logic [31:0] exp;
    logic [31:0] got;
    logic [6:0]  cnt;
    int          done_cyc;
  } res_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_exp, fail_got;
  logic [CNT_W-1:0]  err_count;
  logic              mem_ena, mem_wena;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  ram_march_tester #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PATTERN(PATTERN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .fail_addr(fail_addr),
    .fail_exp (fail_exp),
    .fail_got (fail_got),
    .err_count(err_count),
    .mem_ena  (mem_ena),
    .mem_wena (mem_wena),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic fail_now(input string name, input int info);
    n_checks++;
    $display("FAIL %s: got %0d expected none", name, info);
  endtask

  // ---------------- faulty RAM environment ----------------
  fault_t      fmode    = F_NONE;
  int          fbit     = 0;
  logic [4:0]  faddr    = '0;
  bit          reg_read = 1'b0;
  logic [31:0] mem [N];
  logic [31:0] rdata_q  = '0;

  function automatic logic [4:0] phys(fault_t m, int b, logic [4:0] a);
    if (m == F_ALIAS) return a & ~(5'(1) << b);
    return a;
  endfunction

  function automatic logic [31:0] corrupt(fault_t m, int b, logic [4:0] fa,
                                          logic [4:0] a, logic [31:0] v);
    case (m)
      F_STUCK0: return v & ~(32'(1) << b);
      F_STUCK1: return v | (32'(1) << b);
      F_FLIP:   return (a == fa) ? (v ^ (32'(1) << b)) : v;
      default:  return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_ena && mem_wena) mem[phys(fmode, fbit, mem_addr)] <= mem_wdata;
    if (mem_ena && !mem_wena)
      rdata_q <= corrupt(fmode, fbit, faddr, mem_addr, mem[phys(fmode, fbit, mem_addr)]);
  end

  assign mem_rdata = reg_read ? rdata_q
                              : corrupt(fmode, fbit, faddr, mem_addr, mem[phys(fmode, fbit, mem_addr)]);

  // ---------------- reference model + scoreboard queues ----------------
  wr_t  exp_wr[$];
  res_t exp_res[$];

  function automatic logic [31:0] word(logic [4:0] a);
    return PATTERN ^ 32'(a);
  endfunction

  // Abstract march: two passes over an array (true then inverted data),
  // each pass writes every address then reads every address in the same order.
  task automatic model_march(input fault_t m, input int b, input logic [4:0] fa);
    logic [31:0] arr [N];
    res_t        r;
    logic [4:0]  a;
    logic [31:0] wv, got;
    r.fail = 1'b0; r.addr = '0; r.exp = '0; r.got = '0; r.cnt = '0;
    r.done_cyc = 6 * N + 1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++) begin
        a  = (p == 0) ? 5'(i) : 5'(N - 1 - i);
        wv = (p == 0) ? word(a) : ~word(a);
        arr[phys(m, b, a)] = wv;
        exp_wr.push_back('{(p == 0) ? i + 1 : 3 * N + 1 + i, a, wv});
      end
      for (int i = 0; i < N; i++) begin
        a   = (p == 0) ? 5'(i) : 5'(N - 1 - i);
        wv  = (p == 0) ? word(a) : ~word(a);
        got = corrupt(m, b, fa, a, arr[phys(m, b, a)]);
        if (got != wv) begin
          if (!r.fail) begin
            r.fail = 1'b1; r.addr = a; r.exp = wv; r.got = got;
          end
          if (r.cnt != 7'h7F) r.cnt = r.cnt + 7'd1;
        end
      end
    end
    exp_res.push_back(r);
  endtask

  // ---------------- monitor ----------------
  int   cyc   = 0;
  bit   armed = 1'b0;
  logic done_q = 1'b0;

  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    if (armed) cyc++;
    if (mem_ena && mem_wena) begin
      if (exp_wr.size() == 0) fail_now("unexpected_write", cyc);
      else begin
        w = exp_wr.pop_front();
        check("write_cyc_addr_data", 128'({16'(cyc), mem_addr, mem_wdata}),
              128'({16'(w.cyc), w.addr, w.data}));
      end
    end
    if (done && !done_q) begin
      if (exp_res.size() == 0) fail_now("unexpected_done", cyc);
      else begin
        r = exp_res.pop_front();
        check("fail",      128'(fail),      128'(r.fail));
        check("fail_addr", 128'(fail_addr), 128'(r.addr));
        check("fail_exp",  128'(fail_exp),  128'(r.exp));
        check("fail_got",  128'(fail_got),  128'(r.got));
        check("err_count", 128'(err_count), 128'(r.cnt));
        check("done_cycle", 128'(cyc),      128'(r.done_cyc));
        check("busy_at_done", 128'(busy),   128'(0));
      end
    end
    done_q = done;
    if (rst) armed = 1'b0;
    else if (start && !busy) begin
      armed = 1'b1;
      cyc   = 0;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] all_outputs();
    return 128'({busy, done, fail, fail_addr, fail_exp, fail_got, err_count,
                 mem_ena, mem_wena, mem_addr, mem_wdata});
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run(input fault_t m, input int b, input logic [4:0] fa,
                     input bit rr, input int repulse);
    int k;
    fmode = m; fbit = b; faddr = fa; reg_read = rr;
    model_march(m, b, fa);
    pulse_start();
    k = 1;
    while (!done && k < 300) begin
      start = (k == repulse);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    if (!done) fail_now("done_timeout", k);
    @(posedge clk); #1;
  endtask

  task automatic abort_run();
    fmode = F_NONE; reg_read = 1'b0;
    model_march(F_NONE, 0, '0);
    pulse_start();
    repeat (49) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("outputs_after_abort", all_outputs(), 128'(0));
    exp_wr.delete();
    exp_res.delete();
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("quiet_after_abort", 128'({mem_ena, mem_wena, busy, done}), 128'(0));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run(F_NONE,   0, '0, 1'b0, 0);
    run(F_STUCK0, 3, '0, 1'b0, 0);
    run(F_ALIAS,  4, '0, 1'b1, 0);
    run(F_NONE,   0, '0, 1'b1, 20);
    abort_run();
    run(F_NONE,   0, '0, 1'b0, 0);
    run(F_STUCK1, 0, '0, 1'b1, 0);
    run(F_NONE,   0, '0, 1'b0, 0);

    for (int t = 0; t < 6; t++) begin
      fault_t m;
      int     b;
      m = fault_t'($urandom_range(4, 0));
      b = (m == F_ALIAS) ? int'($urandom_range(ADDR_W - 1, 0)) : int'($urandom_range(31, 0));
      run(m, b, 5'($urandom_range(N - 1, 0)), 1'($urandom_range(1, 0)),
          int'($urandom_range(190, 2)));
    end

    check("scoreboard_drained", 128'(exp_wr.size() + exp_res.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
